ui_text_loader: RTL and testbench
=================================

// Module: ui_text_loader
// PURPOSE
//   Producer side of the UI text overlay. It accepts a "show message" command over a
//   valid/ready handshake, then copies the selected string from an internal string ROM
//   into a character buffer, one character per clock.
//   It also computes the centred horizontal extent of the string. The overlay renderer
//   reads the buffer through a 1-cycle registered read port, keyed by character address.
// PARAMETERS
//   MAX_CHARS      20   character buffer depth; strings longer than this are truncated
//   DISPLAY_WIDTH  160  active display width in pixels, used for centring
//   CHAR_WIDTH     8    pixel width of one glyph
// PORTS
//   clk               in   1   system clock
//   reset             in   1   asynchronous reset, active-high
//   cmd_valid         in   1   command request
//   cmd_ready         out  1   command accepted when cmd_valid && cmd_ready at a rising edge
//   cmd_string_index  in   3   0 "Camera not detected" (19 chars), 1 "SRAM exported" (13 chars),
//                              2-7 empty string
//   cmd_clear         in   1   sampled with the command; 1 = blank overlay, index ignored
//   rd_addr           in   5   renderer character address
//   rd_char           out  8   ASCII at rd_addr, 1-cycle latency
//   text_length       out  5   committed string length
//   text_start_x      out  10  committed first pixel column
//   text_end_x        out  10  committed column one past the last pixel
//   text_visible      out  1   committed string valid and displayable
// BEHAVIOUR
//   Reset values (async):
//     cmd_ready=1, rd_char=8'h20, text_length=0, text_start_x=0, text_end_x=0,
//     text_visible=0, FSM=IDLE.
//   Buffer contents are not reset; they are never exposed because text_length=0.
//   FSM states: IDLE, LOAD, COMMIT. cmd_ready = (state==IDLE).
//   IDLE, command accepted at edge E0:
//     - cmd_clear=1, or the selected string has length 0: at E0 text_visible=0 and
//       text_length=0; start_x/end_x are set to 0; stay in IDLE.
//     - otherwise: latch the index; len = min(rom_len, MAX_CHARS); i=0; text_visible=0
//       at E0; go to LOAD.
//   LOAD:
//     - at each edge write buf[i] = rom[index][i] and increment i.
//     - after the edge that writes i=len-1, go to COMMIT.
//     - the write occupies edges E1..E(len).
//   COMMIT, edge E(len+1):
//     - text_length = len
//     - text_start_x = (DISPLAY_WIDTH - len*CHAR_WIDTH) >> 1
//     - text_end_x = text_start_x + len*CHAR_WIDTH
//     - text_visible = 1
//     - go to IDLE
//   Command-to-visible latency is len+1 cycles (19 chars -> 20 cycles).
//   Arithmetic: all x math is 10-bit unsigned. A length whose width exceeds
//     DISPLAY_WIDTH is clamped so that start_x = 0.
//   Read port: rd_char registered every cycle:
//     - buf[rd_addr] if rd_addr < text_length, else 8'h20 (space, renders blank).
//     - Reads use the committed text_length, so a read during LOAD returns 8'h20.
//   cmd_valid while cmd_ready=0 is ignored; the requester must hold it until accepted.
//   Re-issuing the currently shown string reloads it; text_visible drops for len+1 cycles.
//   Reset during LOAD: the FSM returns to IDLE, outputs take reset values, and the
//     partial load is discarded.
//   Write and read of the same address in one cycle: rd_char returns the old value
//     (read-before-write).
// TESTING
//   1. Reset, then cmd index=0 -> accept at E0; text_visible=1 at E20; length=19,
//      start_x=4, end_x=156. rd_addr 0..18 returns "Camera not detected"; rd_addr=19
//      returns 8'h20.
//   2. Cmd index=1 -> after 14 cycles: length=13, start_x=28, end_x=132;
//      rd_addr=0 gives "S" one cycle later.
//   3. cmd_valid held during a LOAD -> cmd_ready=0, no restart. After COMMIT the held
//      command is accepted and loads next.
//   4. Visible string, then cmd_clear=1 -> text_visible=0 and length=0 at E0;
//      rd_char=8'h20 for all addresses.
//   5. Index 5 -> text_visible=0, length=0, still IDLE, cmd_ready stays 1.
//   6. Assert reset at cycle 7 of a LOAD for index 0 -> all outputs at reset values;
//      a new cmd index=1 completes normally.

Source files
------------

// File: rtl/ui_text_loader.sv
// rtl/ui_text_loader.sv - copies a ROM string into a character buffer and computes its centred extent
// Buffer is filled one character per clock; the renderer reads it through a registered port.
module ui_text_loader #(
  parameter int MAX_CHARS     = 20,
  parameter int DISPLAY_WIDTH = 160,
  parameter int CHAR_WIDTH    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_string_index,
  input  logic       cmd_clear,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [4:0] text_length,
  output logic [9:0] text_start_x,
  output logic [9:0] text_end_x,
  output logic       text_visible
);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  localparam logic [0:18][7:0] STR0    = "Camera not detected";
  localparam logic [0:12][7:0] STR1    = "SRAM exported";
  localparam logic [9:0]       DISP_W  = 10'(DISPLAY_WIDTH);
  localparam logic [9:0]       CHAR_W  = 10'(CHAR_WIDTH);
  localparam logic [4:0]       MAX_LEN = 5'(MAX_CHARS);

  state_t     state, state_next;
  logic [2:0] idx_q;
  logic [4:0] len_q;
  logic [4:0] load_i;
  logic [4:0] rom_len_sel;
  logic [4:0] sel_len;
  logic       cmd_accept;
  logic [9:0] px_width;
  logic [9:0] start_calc;
  logic [7:0] char_buf [MAX_CHARS];

  function automatic logic [4:0] rom_len(input logic [2:0] idx);
    case (idx)
      3'd0:    rom_len = 5'd19;
      3'd1:    rom_len = 5'd13;
      default: rom_len = 5'd0;
    endcase
  endfunction

  function automatic logic [7:0] rom_char(input logic [2:0] idx, input logic [4:0] pos);
    rom_char = 8'h20;
    if (idx == 3'd0 && pos < 5'd19)
      rom_char = STR0[pos];
    else if (idx == 3'd1 && pos < 5'd13)
      rom_char = STR1[pos[3:0]];
  endfunction

  assign rom_len_sel = rom_len(cmd_string_index);
  assign sel_len     = (rom_len_sel > MAX_LEN) ? MAX_LEN : rom_len_sel;
  assign cmd_accept  = cmd_valid && cmd_ready;

  // Strings wider than the display are pinned to column 0 instead of wrapping negative.
  assign px_width   = {5'd0, len_q} * CHAR_W;
  assign start_calc = (px_width > DISP_W) ? 10'd0 : ((DISP_W - px_width) >> 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && !cmd_clear && sel_len != 5'd0)
          state_next = LOAD;
      end
      LOAD:    if (load_i == len_q - 5'd1) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q        <= 3'd0;
      len_q        <= 5'd0;
      load_i       <= 5'd0;
      rd_char      <= 8'h20;
      text_length  <= 5'd0;
      text_start_x <= 10'd0;
      text_end_x   <= 10'd0;
      text_visible <= 1'b0;
    end else begin
      rd_char <= (rd_addr < text_length) ? char_buf[rd_addr] : 8'h20;
      case (state)
        IDLE: if (cmd_accept) begin
          text_visible <= 1'b0;
          text_length  <= 5'd0;
          if (cmd_clear || sel_len == 5'd0) begin
            text_start_x <= 10'd0;
            text_end_x   <= 10'd0;
          end else begin
            idx_q  <= cmd_string_index;
            len_q  <= sel_len;
            load_i <= 5'd0;
          end
        end
        LOAD: load_i <= load_i + 5'd1;
        COMMIT: begin
          text_length  <= len_q;
          text_start_x <= start_calc;
          text_end_x   <= start_calc + px_width;
          text_visible <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Buffer is intentionally unreset; text_length gates every read of it.
  always_ff @(posedge clk) begin
    if (state == LOAD)
      char_buf[load_i] <= rom_char(idx_q, load_i);
  end

endmodule

// File: tb/tb_ui_text_loader.sv
// tb/tb_ui_text_loader.sv - scoreboard bench for ui_text_loader
module tb_ui_text_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_string_index;
  logic       cmd_clear;
  logic [4:0] rd_addr;
  logic [7:0] rd_char;
  logic [4:0] text_length;
  logic [9:0] text_start_x;
  logic [9:0] text_end_x;
  logic       text_visible;

  ui_text_loader dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_string_index(cmd_string_index), .cmd_clear(cmd_clear),
    .rd_addr(rd_addr), .rd_char(rd_char), .text_length(text_length),
    .text_start_x(text_start_x), .text_end_x(text_end_x), .text_visible(text_visible)
  );

  always #5 clk = ~clk;

  typedef struct {int len; int sx; int ex; int lat;} commit_t;
  commit_t    commit_q[$];
  logic [7:0] rd_q[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   accept_cyc = 0;
  logic prev_vis = 1'b0;
  logic rd_req   = 1'b0;
  logic rd_req_d = 1'b0;

  string s0 = "Camera not detected";
  string s1 = "SRAM exported";

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Commit monitor: every rising text_visible must match the oldest queued expectation.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cmd_valid && cmd_ready && !reset) accept_cyc = cyc;
    rd_req_d <= rd_req;
    #1;
    if (text_visible && !prev_vis) begin
      if (commit_q.size() == 0) begin
        chk("unexpected_commit", 1, 0);
      end else begin
        commit_t e;
        e = commit_q.pop_front();
        chk("commit_length",  int'(text_length),  e.len);
        chk("commit_start_x", int'(text_start_x), e.sx);
        chk("commit_end_x",   int'(text_end_x),   e.ex);
        chk("commit_latency", cyc - accept_cyc,   e.lat);
      end
    end
    prev_vis = text_visible;
  end

  // Read monitor: one cycle after a requested address, rd_char must match.
  always @(negedge clk) begin
    if (rd_req_d) begin
      if (rd_q.size() == 0) chk("unexpected_read", 1, 0);
      else                  chk("rd_char", int'(rd_char), int'(rd_q.pop_front()));
    end
  end

  task automatic push_commit(input int len, input int sx, input int ex, input int lat);
    commit_t e;
    e.len = len; e.sx = sx; e.ex = ex; e.lat = lat;
    commit_q.push_back(e);
  endtask

  task automatic send_cmd(input logic [2:0] idx, input logic clr);
    int n;
    cmd_string_index = idx;
    cmd_clear        = clr;
    cmd_valid        = 1'b1;
    n = 0;
    while (!cmd_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("cmd_accept_timeout", 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_clear = 1'b0;
  endtask

  task automatic wait_commits();
    int n;
    n = 0;
    while (commit_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (commit_q.size() != 0) begin
      chk("commit_timeout", commit_q.size(), 0);
      commit_q.delete();
    end
  endtask

  task automatic rd(input logic [4:0] addr, input logic [7:0] exp);
    rd_addr = addr;
    rd_req  = 1'b1;
    rd_q.push_back(exp);
    @(negedge clk);
  endtask

  task automatic rd_done();
    rd_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle_blank(input string tag);
    chk({tag, "_visible"}, int'(text_visible), 0);
    chk({tag, "_length"},  int'(text_length),  0);
    chk({tag, "_start_x"}, int'(text_start_x), 0);
    chk({tag, "_end_x"},   int'(text_end_x),   0);
    chk({tag, "_ready"},   int'(cmd_ready),    1);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_string_index = 3'd0; cmd_clear = 1'b0; rd_addr = 5'd0;
    repeat (3) @(negedge clk);
    chk_idle_blank("reset");
    chk("reset_rd_char", int'(rd_char), 8'h20);
    reset = 1'b0;
    @(negedge clk);

    // 19-char string, centred at 4..156
    push_commit(19, 4, 156, 20);
    send_cmd(3'd0, 1'b0);
    wait_commits();
    for (int a = 0; a < 19; a++) rd(5'(a), 8'(s0[a]));
    rd(5'd19, 8'h20);
    rd(5'd31, 8'h20);
    rd_done();

    // 13-char string
    push_commit(13, 28, 132, 14);
    send_cmd(3'd1, 1'b0);
    wait_commits();
    rd(5'd0, 8'(s1[0]));
    rd(5'd12, 8'(s1[12]));
    rd(5'd13, 8'h20);
    rd_done();

    // Command held during a load waits for the current one to commit
    push_commit(19, 4, 156, 20);
    push_commit(13, 28, 132, 14);
    send_cmd(3'd0, 1'b0);
    cmd_string_index = 3'd1;
    cmd_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("held_cmd_ready", int'(cmd_ready), 0);
    chk("load_visible", int'(text_visible), 0);
    rd(5'd0, 8'h20);
    rd_done();
    send_cmd(3'd1, 1'b0);
    wait_commits();
    rd(5'd4, 8'(s1[4]));
    rd_done();

    // Clear blanks everything immediately
    send_cmd(3'd0, 1'b1);
    chk_idle_blank("clear");
    rd(5'd0, 8'h20);
    rd(5'd5, 8'h20);
    rd(5'd12, 8'h20);
    rd_done();

    // Empty string index
    push_commit(13, 28, 132, 14);
    send_cmd(3'd1, 1'b0);
    wait_commits();
    send_cmd(3'd5, 1'b0);
    chk_idle_blank("empty");
    repeat (3) @(negedge clk);
    chk_idle_blank("empty_later");

    // Reset in the middle of a load
    send_cmd(3'd0, 1'b0);
    repeat (6) @(negedge clk);
    chk("mid_load_ready", int'(cmd_ready), 0);
    reset = 1'b1;
    #1;
    chk_idle_blank("mid_reset");
    chk("mid_reset_rd_char", int'(rd_char), 8'h20);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    push_commit(13, 28, 132, 14);
    send_cmd(3'd1, 1'b0);
    wait_commits();
    rd(5'd0, 8'(s1[0]));
    rd(5'd13, 8'h20);
    rd_done();

    repeat (3) @(negedge clk);
    chk("pending_commits", commit_q.size(), 0);
    chk("pending_reads", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
